ball_engine: RTL

Parametrised successor to the fixed-geometry ball controller. It moves a square ball across a configurable playfield on a programmable tick, bounces it off the top/bottom walls and two paddles, and steers the bounce angle by the paddle contact zone using a fractional-slope accumulator. It reports points through a serve/score handshake and sits between the paddle controllers and the VGA draw pipeline.

---
 rtl/ball_pkg.sv | 15 +
 rtl/vga_pkg.sv | 5 +
 rtl/ball_engine_if.sv | 20 ++
 rtl/ball_tick_gen.sv | 20 ++
 rtl/ball_engine.sv | 131 +++++++++++++
 5 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: ball engine state enum, default geometry and zone-to-slope constants
package ball_pkg;
    import vga_pkg::*;
    typedef enum logic [1:0] {IDLE, PLAY, SCORED} ball_state_t;
    localparam int DEF_H_RES = HOR_PIXELS;
    localparam int DEF_V_RES = VER_PIXELS;
    localparam int DEF_BALL_SIZE = 10;
    localparam int DEF_PAD_H = 100;
    localparam int DEF_PAD_W = 20;
    localparam int DEF_PAD_L_X = 30;
    localparam int DEF_PAD_R_X = 750;
    // slope = 2^FRAC_W >> shift: edge zones steep, centre zones shallow
    localparam int SLOPE_STEEP_SHIFT = 0;
    localparam int SLOPE_SHALLOW_SHIFT = 2;
endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry shared by the VGA draw pipeline and its clients
package vga_pkg;
    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;
endpackage

// File: rtl/ball_engine_if.sv
// ball_engine_if: serve/paddle inputs and ball position/event outputs
//   master: paddle/game controller side; slave: ball_engine
//   serve, serve_dir, pad_l_y, pad_r_y -> engine
//   xpos, ypos, in_play, hit, point_l, point_r <- engine
interface ball_engine_if #(parameter int POS_W = 11);
    logic serve;
    logic serve_dir;
    logic [POS_W-1:0] pad_l_y;
    logic [POS_W-1:0] pad_r_y;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic in_play;
    logic hit;
    logic point_l;
    logic point_r;
    modport master(output serve, serve_dir, pad_l_y, pad_r_y,
                   input xpos, ypos, in_play, hit, point_l, point_r);
    modport slave(input serve, serve_dir, pad_l_y, pad_r_y,
                  output xpos, ypos, in_play, hit, point_l, point_r);
endinterface

// File: rtl/ball_tick_gen.sv
// ball_tick_gen: programmable-period tick counter
//   clk, rst_n (sync, active-low); clr restarts the count
//   period: tick spacing in clk cycles; tick high when count == period-1
module ball_tick_gen #(
    parameter int TICK_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [TICK_W-1:0] period,
    output logic              tick
);
    logic [TICK_W-1:0] cnt;

    assign tick = cnt == period - TICK_W'(1);

    always_ff @(posedge clk)
        if (!rst_n || clr || tick) cnt <= '0;
        else cnt <= cnt + TICK_W'(1);
endmodule

// File: rtl/ball_engine.sv
// ball_engine: moves and bounces the ball, steers by paddle zone, reports points
//   clk, rst_n (sync, active-low); bus (ball_engine_if.slave) carries
//   serve/serve_dir/paddle tops in and xpos/ypos/in_play/hit/point_l/point_r out
//   BALL_SPEEDUP_EN: each paddle hit shortens the tick period down to TICK_MIN
module ball_engine
    import ball_pkg::*;
#(
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int POS_W      = 11,
    parameter int BALL_SIZE  = DEF_BALL_SIZE,
    parameter int PAD_H      = DEF_PAD_H,
    parameter int PAD_W      = DEF_PAD_W,
    parameter int PAD_L_X    = DEF_PAD_L_X,
    parameter int PAD_R_X    = DEF_PAD_R_X,
    parameter int FRAC_W     = 3,
    parameter int TICK_W     = 20,
    parameter int TICK_START = 200000,
    parameter int TICK_MIN   = 50000,
    parameter int TICK_STEP  = 10000
) (
    input logic          clk,
    input logic          rst_n,
    ball_engine_if.slave bus
);
    localparam logic [POS_W-1:0] X_C   = POS_W'((H_RES - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0] Y_C   = POS_W'((V_RES - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0] X_PL  = POS_W'(PAD_L_X + PAD_W);
    localparam logic [POS_W-1:0] X_PR  = POS_W'(PAD_R_X - BALL_SIZE);
    localparam logic [POS_W-1:0] X_MAX = POS_W'(H_RES - BALL_SIZE);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_RES - BALL_SIZE);
    localparam logic [FRAC_W:0]  ONE   = (FRAC_W+1)'(1 << FRAC_W);
    localparam logic [FRAC_W:0]  S_STEEP   = (FRAC_W+1)'((1 << FRAC_W) >> SLOPE_STEEP_SHIFT);
    localparam logic [FRAC_W:0]  S_SHALLOW = (FRAC_W+1)'((1 << FRAC_W) >> SLOPE_SHALLOW_SHIFT);
    localparam logic [POS_W+2:0] ZDIV  = (POS_W+3)'(PAD_H + BALL_SIZE);

    ball_state_t state, state_nx;
    logic [POS_W-1:0] xpos, ypos;
    logic dirx, diry, hit_q, side_l;
    logic [FRAC_W:0] slope, acc, slope_n, acc_sum;
    logic [TICK_W-1:0] period;
    logic tick, step, hit_l, hit_r, pad_hit, score_l, score_r, steep, dy_z, dy_n, dx_n, wall, carry;
    logic [POS_W:0] y_top, y_bot, pl, pr, off;
    logic [1:0] zone;

    ball_tick_gen #(.TICK_W(TICK_W)) u_tick (
        .clk(clk), .rst_n(rst_n), .clr(state != PLAY), .period(period), .tick(tick)
    );

`ifdef BALL_SPEEDUP_EN
    always_ff @(posedge clk)
        if (!rst_n || state != PLAY) period <= TICK_W'(TICK_START);
        else if (step && pad_hit)
            period <= period >= TICK_W'(TICK_MIN + TICK_STEP) ? period - TICK_W'(TICK_STEP) : TICK_W'(TICK_MIN);
`else
    assign period = TICK_W'(TICK_START);
`endif

    // Bounce decisions, all widened by one bit so ypos+BALL_SIZE cannot wrap
    assign step    = state == PLAY && tick;
    assign y_top   = {1'b0, ypos};
    assign y_bot   = y_top + (POS_W+1)'(BALL_SIZE);
    assign pl      = {1'b0, bus.pad_l_y};
    assign pr      = {1'b0, bus.pad_r_y};
    assign hit_l   = !dirx && xpos == X_PL && y_bot > pl && y_top < pl + (POS_W+1)'(PAD_H);
    assign hit_r   = dirx && xpos == X_PR && y_bot > pr && y_top < pr + (POS_W+1)'(PAD_H);
    assign pad_hit = hit_l || hit_r;
    assign off     = y_bot - (dirx ? pr : pl);
    assign zone    = 2'(({2'b00, off} << 2) / ZDIV);
    assign steep   = zone == 2'd0 || zone == 2'd3;
    assign score_r = !pad_hit && !dirx && xpos == '0;
    assign score_l = !pad_hit && dirx && xpos == X_MAX;
    assign dx_n    = dirx ^ pad_hit;
    assign dy_z    = pad_hit && steep ? zone == 2'd3 : diry;
    // Wall reflection sees the zone-updated direction
    assign wall    = dy_z ? ypos == Y_MAX : ypos == '0;
    assign dy_n    = dy_z ^ wall;
    assign slope_n = pad_hit ? (steep ? S_STEEP : S_SHALLOW) : slope;
    assign acc_sum = (pad_hit ? '0 : acc) + slope_n;
    assign carry   = acc_sum >= ONE;

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (bus.serve ? PLAY : IDLE) :
                   state == PLAY ? (step && (score_l || score_r) ? SCORED : PLAY) : IDLE;

    always_comb begin
        bus.xpos    = xpos;
        bus.ypos    = ypos;
        bus.in_play = state == PLAY;
        bus.hit     = hit_q;
        bus.point_l = state == SCORED && side_l;
        bus.point_r = state == SCORED && !side_l;
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            xpos   <= X_C;
            ypos   <= Y_C;
            dirx   <= 1'b0;
            diry   <= 1'b1;
            slope  <= S_SHALLOW;
            acc    <= '0;
            hit_q  <= 1'b0;
            side_l <= 1'b0;
        end else if (state == SCORED) begin
            xpos  <= X_C;
            ypos  <= Y_C;
            hit_q <= 1'b0;
        end else if (state == IDLE && bus.serve) begin
            dirx  <= bus.serve_dir;
            diry  <= 1'b1;
            slope <= S_SHALLOW;
            acc   <= '0;
            hit_q <= 1'b0;
        end else if (step) begin
            hit_q  <= pad_hit;
            side_l <= score_l;
            dirx   <= dx_n;
            diry   <= dy_n;
            if (!(score_l || score_r)) begin
                xpos  <= dx_n ? xpos + POS_W'(1) : xpos - POS_W'(1);
                slope <= slope_n;
                acc   <= carry ? acc_sum - ONE : acc_sum;
                if (carry) ypos <= dy_n ? ypos + POS_W'(1) : ypos - POS_W'(1);
            end
        end else hit_q <= 1'b0;
endmodule
